// File: rtl/ififo_pkg.sv
// ififo_pkg -- shared constants for the ififo bank.
//   DEF_BW / DEF_DEPTH / DEF_CH : default lane word width, lane depth, lane count
//   DEF_CNT_W                   : lane count width for the default depth
//   cnt_width()                 : lane count width for an arbitrary depth; one
//                                 extra bit so that a count of DEPTH fits
package ififo_pkg;

  localparam int DEF_BW    = 4;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CH    = 8;
  localparam int DEF_CNT_W = $clog2(DEF_DEPTH) + 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ififo_lane.sv
// ififo_lane -- storage, write pointer and occupancy count of one bank lane.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   wr_en, data_in    write request and word for this lane
//   pop               row pop accepted by the bank this cycle
//   rd_ptr            shared read pointer owned by the bank
//   rd_word           word currently at rd_ptr (combinational read)
//   count             words held, 0..DEPTH
//   full, almost_full count == DEPTH, count >= AF_LVL
//   wr_drop           write requested while the lane is full
module ififo_lane
  import ififo_pkg::*;
#(
  parameter int BW     = DEF_BW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEF_DEPTH - 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [BW-1:0] data_in,
  input  logic          pop,
  input  logic [AW-1:0] rd_ptr,
  output logic [BW-1:0] rd_word,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          almost_full,
  output logic          wr_drop
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);

  logic [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr_acc;

  // Acceptance looks only at the count at the start of the cycle, so a pop
  // in the same cycle never frees room for a write to a full lane.
  assign w_wr_acc = wr_en & (r_count != FULL_CNT);

  // Storage is not reset; the cleared count makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      // The bank only pops when every lane is non-empty, so no underflow.
      case ({w_wr_acc, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_word     = r_mem[rd_ptr];
  assign count       = r_count;
  assign full        = (r_count == FULL_CNT);
  assign almost_full = (r_count >= AF_CNT);
  assign wr_drop     = wr_en & full;

endmodule

// File: rtl/ififo_bank.sv
// ififo_bank -- CH independent write lanes popped together as one row.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   wr_en         per-lane write request, data_in lane i at [i*BW +: BW]
//   rd_en         row pop request, honoured only while rd_ready
//   data_out      registered popped row, holds between pops
//   rd_valid      one-cycle pulse: data_out was updated on this edge
//   rd_ready      every lane non-empty
//   full          some lane holds DEPTH words
//   almost_full   some lane count >= AF_LVL
//   empty         every lane holds zero words
//   overflow      sticky: a write to a full lane was dropped
module ififo_bank
  import ififo_pkg::*;
#(
  parameter int BW     = DEF_BW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CH     = DEF_CH,
  parameter int AF_LVL = DEPTH - 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CH-1:0]    wr_en,
  input  logic [CH*BW-1:0] data_in,
  input  logic             rd_en,
  output logic [CH*BW-1:0] data_out,
  output logic             rd_valid,
  output logic             rd_ready,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [CH-1:0]    w_full;
  logic [CH-1:0]    w_af;
  logic [CH-1:0]    w_nonempty;
  logic [CH-1:0]    w_drop;
  logic [CH*BW-1:0] w_row;
  logic             w_pop;

  logic [AW-1:0]    r_rd_ptr;
  logic [CH*BW-1:0] r_data_out;
  logic             r_rd_valid;
  logic             r_overflow;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      logic [CW-1:0] w_count;

      ififo_lane #(
        .BW     (BW),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL)
      ) u_lane (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en[gi]),
        .data_in     (data_in[gi*BW +: BW]),
        .pop         (w_pop),
        .rd_ptr      (r_rd_ptr),
        .rd_word     (w_row[gi*BW +: BW]),
        .count       (w_count),
        .full        (w_full[gi]),
        .almost_full (w_af[gi]),
        .wr_drop     (w_drop[gi])
      );

      assign w_nonempty[gi] = |w_count;
    end
  endgenerate

  // Flags come straight from the current counts, so a write is visible in
  // rd_ready only after its edge (no fall-through).
  assign rd_ready    = &w_nonempty;
  assign empty       = ~|w_nonempty;
  assign full        = |w_full;
  assign almost_full = |w_af;
  assign w_pop       = rd_en & rd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= '0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_data_out <= w_row;
        r_rd_ptr   <= r_rd_ptr + AW'(1);
      end
      if (|w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_ififo_bank.sv
// tb_ififo_bank -- scoreboard bench for ififo_bank (BW=4, DEPTH=8, CH=8).
module tb_ififo_bank;

  localparam int BW     = 4;
  localparam int DEPTH  = 8;
  localparam int CH     = 8;
  localparam int AF_LVL = DEPTH - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [CH-1:0]    wr_en = '0;
  logic [CH*BW-1:0] data_in = '0;
  logic             rd_en = 1'b0;
  logic [CH*BW-1:0] data_out;
  logic             rd_valid;
  logic             rd_ready;
  logic             full;
  logic             almost_full;
  logic             empty;
  logic             overflow;

  // Reference model: one queue per lane, sticky overflow, last popped row.
  logic [BW-1:0]    mq [CH][$];
  logic [CH*BW-1:0] sb [$];
  logic             m_ovf;
  logic [CH*BW-1:0] m_dout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ififo_bank #(
    .BW     (BW),
    .DEPTH  (DEPTH),
    .CH     (CH),
    .AF_LVL (AF_LVL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .overflow    (overflow)
  );

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  function automatic logic [CH*BW-1:0] row_of(input int base);
    logic [CH*BW-1:0] r;
    for (int i = 0; i < CH; i++) r[i*BW +: BW] = BW'(base + i);
    return r;
  endfunction

  function automatic logic [CH*BW-1:0] row_same(input int v);
    logic [CH*BW-1:0] r;
    for (int i = 0; i < CH; i++) r[i*BW +: BW] = BW'(v);
    return r;
  endfunction

  function automatic logic [4:0] model_flags();
    logic ef, eaf, ee, er;
    ef = 0; eaf = 0; ee = 1; er = 1;
    for (int i = 0; i < CH; i++) begin
      if (mq[i].size() == DEPTH)  ef  = 1;
      if (mq[i].size() >= AF_LVL) eaf = 1;
      if (mq[i].size() != 0)      ee  = 0;
      if (mq[i].size() == 0)      er  = 0;
    end
    return {ef, eaf, ee, er, m_ovf};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < CH; i++) mq[i].delete();
    sb.delete();
    m_ovf  = 1'b0;
    m_dout = '0;
  endtask

  // One clock of stimulus: the model decides acceptance from the state at
  // the start of the cycle, pushes the expected row, then the DUT output
  // after the edge is compared.
  task automatic step(input logic [CH-1:0] w, input logic [CH*BW-1:0] d,
                      input logic r, input string tag);
    int               pre_sz [CH];
    logic             pop;
    logic [CH*BW-1:0] row;
    logic [4:0]       got_f, exp_f;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    pop     = r;
    for (int i = 0; i < CH; i++) begin
      pre_sz[i] = mq[i].size();
      if (pre_sz[i] == 0) pop = 1'b0;
    end
    if (pop) begin
      for (int i = 0; i < CH; i++) row[i*BW +: BW] = mq[i].pop_front();
      sb.push_back(row);
    end
    for (int i = 0; i < CH; i++) begin
      if (w[i]) begin
        if (pre_sz[i] < DEPTH) mq[i].push_back(d[i*BW +: BW]);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    wr_en = '0;
    rd_en = 1'b0;
    n_checks++;
    if (rd_valid !== pop)
      $display("FAIL %s rd_valid: got %0b expected %0b", tag, rd_valid, pop);
    else n_pass++;
    if (rd_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0)
        $display("FAIL %s unexpected_pop: got rd_valid=1 expected no pop", tag);
      else begin
        n_pass++;
        m_dout = sb.pop_front();
      end
    end
    n_checks++;
    if (data_out !== m_dout)
      $display("FAIL %s data_out: got %h expected %h", tag, data_out, m_dout);
    else n_pass++;
    got_f = {full, almost_full, empty, rd_ready, overflow};
    exp_f = model_flags();
    n_checks++;
    if (got_f !== exp_f)
      $display("FAIL %s flags{full,af,empty,ready,ovf}: got %b expected %b", tag, got_f, exp_f);
    else n_pass++;
    $display("%s wr=%b rd=%0b -> rd_valid=%0b data_out=%h flags=%b", tag, w, r, rd_valid, data_out, got_f);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    clear_model();
    #2;
    n_checks++;
    if ({full, almost_full, empty, rd_ready, overflow, rd_valid} !== 6'b001000)
      $display("FAIL reset_flags: got %b expected 001000",
               {full, almost_full, empty, rd_ready, overflow, rd_valid});
    else n_pass++;
    n_checks++;
    if (data_out !== '0) $display("FAIL reset_data: got %h expected 0", data_out);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset: flags=%b data_out=%h", {full, almost_full, empty, rd_ready, overflow}, data_out);
  endtask

  task automatic test_fill();
    for (int k = 1; k <= DEPTH; k++) step('1, row_same(k), 1'b0, "fill");
  endtask

  task automatic test_overflow();
    step(CH'(1 << 3), row_same(15), 1'b0, "ovf_wr");
    // Full lane write with a simultaneous pop is still dropped.
    step(CH'(1 << 3), row_same(14), 1'b1, "ovf_wr_pop");
    for (int k = 0; k < 3; k++) step('0, '0, 1'b1, "ovf_pop");
  endtask

  task automatic test_async_reset();
    step('1, row_of(9), 1'b0, "ar_wr");
    #2 reset_n = 1'b0;
    clear_model();
    #1;
    n_checks++;
    if ({full, almost_full, empty, rd_ready, overflow, rd_valid} !== 6'b001000)
      $display("FAIL async_reset_flags: got %b expected 001000",
               {full, almost_full, empty, rd_ready, overflow, rd_valid});
    else n_pass++;
    n_checks++;
    if (data_out !== '0) $display("FAIL async_reset_data: got %h expected 0", data_out);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    step('0, '0, 1'b1, "ar_pop_empty");
    step('1, row_of(3), 1'b0, "ar_first_wr");
    step('0, '0, 1'b1, "ar_pop");
  endtask

  task automatic test_seq();
    for (int k = 1; k <= 3; k++) step('1, row_same(k), 1'b0, "seq_wr");
    for (int k = 0; k < 3; k++)  step('0, '0, 1'b0, "seq_idle");
    for (int k = 0; k < 3; k++)  step('0, '0, 1'b1, "seq_pop");
    n_checks++;
    if (empty !== 1'b1) $display("FAIL seq_empty: got %0b expected 1", empty);
    else n_pass++;
  endtask

  task automatic test_partial();
    step({1'b0, {(CH-1){1'b1}}}, row_of(5), 1'b0, "part_wr");
    step('0, '0, 1'b1, "part_pop_blocked");
    // Write into the empty last lane and pop in the same cycle: no fall-through.
    step(CH'(1 << (CH-1)), row_of(5), 1'b1, "part_wr_last_pop");
    step('0, '0, 1'b1, "part_pop");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++)  step('1, row_of(k), 1'b0, "b2b_prefill");
    for (int k = 3; k < 23; k++) step('1, row_of(k), 1'b1, "b2b_wr_pop");
    for (int k = 0; k < 3; k++)  step('0, '0, 1'b1, "b2b_drain");
  endtask

  initial begin
    clear_model();
    test_reset();
    test_fill();
    test_overflow();
    test_async_reset();
    apply_reset();
    test_seq();
    test_partial();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d rows left expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
